irq_controller: RTL and testbench

Parametrised, Wishbone-slave interrupt controller for the bexkat2 SoC. It replaces the fixed combinational priority encoder that drives cpu_interrupt.
- Supports NSRC sources with per-source enable mask and per-source level/edge mode.
- Holds edge pending bits that software clears (W1C) or forces (W1S).
- Provides a non-maskable top-priority fault input (MMU fault).
- Drives a registered vector to the CPU.
- Sits on the I/O chipselect alongside iocontroller.

---
 rtl/irq_pkg.sv | 31 +++
 rtl/irq_sync_edge.sv | 45 ++++
 rtl/irq_controller.sv | 124 ++++++++++++
 tb/tb_irq_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the bexkat2 interrupt controller.
package irq_pkg;

  // Register word indices
  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_EDGE    = 3'd2;
  localparam logic [2:0] IRQ_CLEAR   = 3'd3;
  localparam logic [2:0] IRQ_FORCE   = 3'd4;
  localparam logic [2:0] IRQ_VECTOR  = 3'd5;

  // Vector encoding towards the CPU
  localparam int VEC_NONE = 0;
  localparam int VEC_NMI  = 1;
  localparam int VEC_BASE = 2;

  // One decoded bus access, valid for the cycle the ack is being raised
  typedef struct packed {
    logic        acc;
    logic        wr;
    logic [2:0]  adr;
    logic [31:0] mask;
    logic [31:0] dat;
  } irq_bus_req_t;

  // Expand byte-lane selects into a bit mask
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit synchroniser with rising-edge detect. prev tracks the
// synchronised value every cycle so mode changes never fake an edge.
module irq_sync_edge
  import irq_pkg::*;
#(
  parameter int SYNC = 2
) (
  input  logic sysclock,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise
);

  logic prev_q;

  generate
    if (SYNC == 0) begin : g_pass
      assign q = d;
    end else begin : g_sync
      logic [SYNC-1:0] sync_q;

      // Shift the raw request through SYNC flops
      always_ff @(posedge sysclock or posedge rst_i) begin
        if (rst_i) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= d;
          for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign q = sync_q[SYNC-1];
    end
  endgenerate

  // Remember last synchronised value for edge detection
  always_ff @(posedge sysclock or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= q;
  end

  assign rise = q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Wishbone-slave interrupt controller: per-source enable and level/edge
// mode, W1C/W1S edge pending, non-maskable fault, registered CPU vector.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int VECW = 3,
  parameter int SYNC = 2
) (
  input  logic            sysclock,
  input  logic            rst_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [2:0]      adr_i,
  input  logic [3:0]      sel_i,
  input  logic [31:0]     dat_i,
  output logic [31:0]     dat_o,
  output logic            ack_o,
  input  logic [NSRC-1:0] irq_i,
  input  logic            nmi_i,
  input  logic            int_en,
  output logic [VECW-1:0] cpu_interrupt
);

  generate
    if (NSRC < 1 || NSRC > 32 || (NSRC + 2) > (1 << VECW)) begin : g_bad_param
      $error("irq_controller: NSRC must be 1..32 and NSRC+2 <= 2**VECW");
    end
  endgenerate

  logic [NSRC-1:0] s, rise;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] clr, frc, active;
  logic [VECW-1:0] vec, cpu_q;
  logic [31:0]     dat_q, rdata;
  logic            ack_q;
  irq_bus_req_t    req;

  // Per-source synchroniser and edge detector
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_sync_edge #(.SYNC(SYNC)) u_sync (
      .sysclock (sysclock),
      .rst_i    (rst_i),
      .d        (irq_i[i]),
      .q        (s[i]),
      .rise     (rise[i])
    );
  end

  // Bus decode and register next-state; writes land on the ack-raising edge
  always_comb begin
    req.acc  = cyc_i & stb_i & ~ack_q;
    req.wr   = req.acc & we_i;
    req.adr  = adr_i;
    req.mask = lane_mask(sel_i);
    req.dat  = dat_i;
    enable_d = enable_q;
    edge_d   = edge_q;
    clr      = '0;
    frc      = '0;
    if (req.wr) begin
      case (req.adr)
        IRQ_ENABLE: enable_d = NSRC'((32'(enable_q) & ~req.mask) | (req.dat & req.mask));
        IRQ_EDGE:   edge_d   = NSRC'((32'(edge_q) & ~req.mask) | (req.dat & req.mask));
        IRQ_CLEAR:  clr      = NSRC'(req.dat & req.mask);
        IRQ_FORCE:  frc      = NSRC'(req.dat & req.mask);
        default: ;
      endcase
    end
  end

  // Pending: level sources mirror s; edge sources latch, set beats clear
  always_comb begin
    pending_d = (edge_q & ((pending_q & ~clr) | rise | frc)) | (~edge_q & s);
  end

  // Priority encoder: NMI first, then highest enabled pending index
  always_comb begin
    active = pending_q & enable_q;
    vec    = VECW'(VEC_NONE);
    for (int i = 0; i < NSRC; i++) begin
      if (active[i]) vec = VECW'(i + VEC_BASE);
    end
    if (nmi_i) vec = VECW'(VEC_NMI);
  end

  // Read mux; write-only and unused slots return 0
  always_comb begin
    case (req.adr)
      IRQ_PENDING: rdata = 32'(pending_q);
      IRQ_ENABLE:  rdata = 32'(enable_q);
      IRQ_EDGE:    rdata = 32'(edge_q);
      IRQ_VECTOR:  rdata = 32'(vec);
      default:     rdata = '0;
    endcase
  end

  // State registers, bus response and the gated CPU vector
  always_ff @(posedge sysclock or posedge rst_i) begin
    if (rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      cpu_q     <= '0;
    end else begin
      ack_q     <= req.acc;
      dat_q     <= (req.acc & ~we_i) ? rdata : '0;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      cpu_q     <= int_en ? vec : '0;
    end
  end

  assign ack_o         = ack_q;
  assign dat_o         = dat_q;
  assign cpu_interrupt = cpu_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, hand-built
// corner sequences and a randomized run against a queue-based model.
module tb_irq_controller;

  localparam int NSRC = 6;
  localparam int VECW = 3;
  localparam int SYNC = 2;

  logic            sysclock = 1'b0;
  logic            rst_i    = 1'b1;
  logic            cyc_i = 0, stb_i = 0, we_i = 0;
  logic [2:0]      adr_i = '0;
  logic [3:0]      sel_i = '0;
  logic [31:0]     dat_i = '0;
  logic [31:0]     dat_o;
  logic            ack_o;
  logic [NSRC-1:0] irq_i = '0;
  logic            nmi_i = 0, int_en = 0;
  logic [VECW-1:0] cpu_interrupt;

  irq_controller #(.NSRC(NSRC), .VECW(VECW), .SYNC(SYNC)) dut (
    .sysclock      (sysclock),
    .rst_i         (rst_i),
    .cyc_i         (cyc_i),
    .stb_i         (stb_i),
    .we_i          (we_i),
    .adr_i         (adr_i),
    .sel_i         (sel_i),
    .dat_i         (dat_i),
    .dat_o         (dat_o),
    .ack_o         (ack_o),
    .irq_i         (irq_i),
    .nmi_i         (nmi_i),
    .int_en        (int_en),
    .cpu_interrupt (cpu_interrupt)
  );

  always #5 sysclock = ~sysclock;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // hist[k] = irq_i value driven k+1 cycles ago; the synchronised view is
  // simply the input delayed by SYNC cycles.
  logic [NSRC-1:0] hist[$];
  logic [NSRC-1:0] m_pend, m_en, m_edge;
  logic            m_ack, m_rd;
  logic [31:0]     m_dat;
  int              m_cpu;

  function automatic int enc(logic [NSRC-1:0] p, logic [NSRC-1:0] e, logic n);
    if (n) return 1;
    for (int i = NSRC - 1; i >= 0; i--) if (p[i] && e[i]) return i + 2;
    return 0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k <= SYNC; k++) hist.push_back('0);
    m_pend = '0; m_en = '0; m_edge = '0;
    m_ack = 0; m_rd = 0; m_dat = '0; m_cpu = 0;
  endfunction

  function automatic void model_step();
    logic            acc;
    logic [NSRC-1:0] sv, pv, c, f;
    logic [31:0]     mk, wm;
    int              v;
    acc = cyc_i && stb_i && !m_ack;
    v = enc(m_pend, m_en, nmi_i);
    m_cpu = int_en ? v : 0;
    m_rd = acc && !we_i;
    if (m_rd) begin
      case (adr_i)
        3'd0: m_dat = 32'(m_pend);
        3'd1: m_dat = 32'(m_en);
        3'd2: m_dat = 32'(m_edge);
        3'd5: m_dat = 32'(v);
        default: m_dat = 32'h0;
      endcase
    end
    sv = (SYNC == 0) ? irq_i : hist[SYNC-1];
    pv = hist[SYNC];
    mk = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    wm = dat_i & mk;
    c = (acc && we_i && adr_i == 3'd3) ? NSRC'(wm) : '0;
    f = (acc && we_i && adr_i == 3'd4) ? NSRC'(wm) : '0;
    for (int i = 0; i < NSRC; i++)
      m_pend[i] = m_edge[i] ? ((m_pend[i] & ~c[i]) | (sv[i] & ~pv[i]) | f[i]) : sv[i];
    if (acc && we_i && adr_i == 3'd1) m_en   = NSRC'((32'(m_en) & ~mk) | wm);
    if (acc && we_i && adr_i == 3'd2) m_edge = NSRC'((32'(m_edge) & ~mk) | wm);
    m_ack = acc;
    hist.push_front(irq_i);
    void'(hist.pop_back());
  endfunction

  // One clock with model update and output comparison
  task automatic cycle();
    @(posedge sysclock);
    model_step();
    #1;
    chk("ack_o", 32'(ack_o), 32'(m_ack));
    chk("cpu_interrupt", 32'(cpu_interrupt), 32'(m_cpu));
    if (m_ack && m_rd) chk("dat_o", dat_o, m_dat);
  endtask

  task automatic bus(input logic w, input logic [2:0] a, input logic [3:0] sl,
                     input logic [31:0] wd, output logic [31:0] rd);
    cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; sel_i = sl; dat_i = wd;
    cycle();
    rd = dat_o;
    cyc_i = 0; stb_i = 0; we_i = 0;
    cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] d;
    bus(1'b1, a, 4'hF, wd, d);
  endtask

  task automatic rd_chk(string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, a, 4'hF, 32'h0, d);
    chk(nm, d, exp);
  endtask

  task automatic do_reset();
    cyc_i = 0; stb_i = 0; we_i = 0; irq_i = '0; nmi_i = 0;
    rst_i = 1;
    model_reset();
    repeat (2) @(posedge sysclock);
    #1 rst_i = 0;
    chk("reset cpu_interrupt", 32'(cpu_interrupt), 32'h0);
    chk("reset ack_o", 32'(ack_o), 32'h0);
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic w, logic [2:0] a, logic [3:0] s, logic [31:0] wd, logic [31:0] e);
    vec_t v;
    v.we = w; v.adr = a; v.sel = s; v.wd = wd; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] d;
    int r;

    // reads after reset, byte-lane writes, RO/WO/unused slots
    for (int i = 0; i < 8; i++) add(0, 3'(i), 4'hF, 0, 0);
    add(1, 3'd1, 4'hF, 32'hFFFF_FFFF, 0);  add(0, 3'd1, 4'hF, 0, 32'h3F);
    add(1, 3'd1, 4'b1110, 32'h0, 0);       add(0, 3'd1, 4'hF, 0, 32'h3F);
    add(1, 3'd1, 4'b0010, 32'h0, 0);       add(0, 3'd1, 4'hF, 0, 32'h3F);
    add(1, 3'd1, 4'b0001, 32'h0, 0);       add(0, 3'd1, 4'hF, 0, 32'h00);
    add(1, 3'd1, 4'b1110, 32'hFFFF_FF00, 0); add(0, 3'd1, 4'hF, 0, 32'h00);
    add(1, 3'd1, 4'b0001, 32'h0000_0015, 0); add(0, 3'd1, 4'hF, 0, 32'h15);
    add(1, 3'd2, 4'hF, 32'h0000_002A, 0);  add(0, 3'd2, 4'hF, 0, 32'h2A);
    add(1, 3'd6, 4'hF, 32'hFFFF_FFFF, 0);  add(0, 3'd6, 4'hF, 0, 32'h0);
    add(1, 3'd7, 4'hF, 32'hFFFF_FFFF, 0);  add(0, 3'd7, 4'hF, 0, 32'h0);
    add(1, 3'd5, 4'hF, 32'hFF, 0);         add(0, 3'd5, 4'hF, 0, 32'h0);
    add(1, 3'd0, 4'hF, 32'hFF, 0);         add(0, 3'd0, 4'hF, 0, 32'h0);
    add(0, 3'd3, 4'hF, 0, 32'h0);          add(0, 3'd4, 4'hF, 0, 32'h0);

    do_reset();
    int_en = 1;
    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd, d);
      if (!tbl[i].we) chk($sformatf("table[%0d] read adr %0d", i, tbl[i].adr), d, tbl[i].exp);
    end

    // level latency: SYNC+2 cycles to vector, and again after a drop
    do_reset();
    wr(3'd1, 32'h3F);
    int_en = 1;
    irq_i = 6'b000101;
    wait_n(SYNC + 1);
    chk("level latency early", 32'(cpu_interrupt), 32'd0);
    cycle();
    chk("level latency vec4", 32'(cpu_interrupt), 32'd4);
    irq_i = 6'b000001;
    wait_n(SYNC + 1);
    chk("drop still vec4", 32'(cpu_interrupt), 32'd4);
    cycle();
    chk("drop vec2", 32'(cpu_interrupt), 32'd2);

    // edge mode: pulse latches, CLEAR drops, set beats clear
    irq_i = '0;
    wait_n(6);
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h01);
    irq_i = 6'b000001; cycle(); irq_i = '0;
    wait_n(5);
    rd_chk("edge pending", 3'd0, 32'h01);
    chk("edge held vec2", 32'(cpu_interrupt), 32'd2);
    wr(3'd3, 32'h01);
    chk("clear drops vec", 32'(cpu_interrupt), 32'd0);
    irq_i = 6'b000001; cycle(); irq_i = '0;
    wait_n(5);
    chk("edge re-armed vec2", 32'(cpu_interrupt), 32'd2);
    irq_i = 6'b000001; cycle(); irq_i = '0;
    wait_n(SYNC - 1);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 3'd3; sel_i = 4'hF; dat_i = 32'h01;
    cycle();
    cyc_i = 0; stb_i = 0; we_i = 0;
    wait_n(2);
    chk("edge+clear keeps vec2", 32'(cpu_interrupt), 32'd2);
    rd_chk("edge+clear pending", 3'd0, 32'h01);

    // NMI priority and int_en gating
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h3F);
    irq_i = 6'h3F;
    wait_n(5);
    chk("all sources vec7", 32'(cpu_interrupt), 32'd7);
    nmi_i = 1;
    cycle();
    chk("nmi vec1", 32'(cpu_interrupt), 32'd1);
    int_en = 0;
    cycle();
    chk("int_en gates", 32'(cpu_interrupt), 32'd0);
    rd_chk("vector reg nmi", 3'd5, 32'd1);
    nmi_i = 0; irq_i = '0; int_en = 1;
    wait_n(5);

    // FORCE while masked, then unmask
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h20);
    wr(3'd4, 32'h20);
    rd_chk("force pending", 3'd0, 32'h20);
    chk("masked vec0", 32'(cpu_interrupt), 32'd0);
    wr(3'd1, 32'h20);
    chk("unmask vec7", 32'(cpu_interrupt), 32'd7);

    // async reset in the middle of an acked read
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 3'd0; sel_i = 4'hF;
    cycle();
    chk("pre-reset ack", 32'(ack_o), 32'd1);
    #2 rst_i = 1;
    #1;
    chk("async ack_o", 32'(ack_o), 32'd0);
    chk("async cpu_interrupt", 32'(cpu_interrupt), 32'd0);
    chk("async dat_o", dat_o, 32'd0);
    chk("async pending", 32'(dut.pending_q), 32'd0);
    cyc_i = 0; stb_i = 0;
    model_reset();
    repeat (2) @(posedge sysclock);
    #1 rst_i = 0;
    rd_chk("post-reset pending", 3'd0, 32'h0);
    rd_chk("post-reset enable", 3'd1, 32'h0);

    // randomized run against the model
    do_reset();
    int_en = 1;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 99) < 30) irq_i = NSRC'($urandom);
      if ($urandom_range(0, 99) < 4)  nmi_i = ~nmi_i;
      if ($urandom_range(0, 99) < 4)  int_en = ~int_en;
      r = $urandom_range(0, 99);
      if (r < 20) begin
        cyc_i = 1; stb_i = 1;
        we_i  = ($urandom_range(0, 2) != 0);
        adr_i = (we_i && $urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
        sel_i = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
        dat_i = $urandom;
        wait_n($urandom_range(1, 3));
        cyc_i = 0; stb_i = 0; we_i = 0;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
